// File: rtl/rv32i_bus_fabric.sv
`default_nettype none
// ============================================================================
// Module : rv32i_bus_fabric
// Desc   : RV32I data-port bus fabric: base/mask slave decode, ready handshake,
//          registered read return, error response for unmapped/hung accesses.
//          Macro RV32I_BUS_TIMEOUT_EN enables the WAIT-state timeout counter.
// Rev    : 1.0 - initial release
// ============================================================================
module rv32i_bus_fabric #(
  parameter int                 NSLV        = 4,
  parameter logic [NSLV*32-1:0] SLV_BASE    = {32'h8000_1000, 32'h8000_0000,
                                               32'h1000_0000, 32'h0000_0000},
  parameter logic [NSLV*32-1:0] SLV_MASK    = {32'hFFFF_F000, 32'hFFFF_F000,
                                               32'hFFFF_C000, 32'hFFFF_C000},
  parameter int                 TIMEOUT_CYC = 16,
  parameter logic [31:0]        ERR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [31:0]          cpu_addr,
  input  logic                 cpu_we,
  input  logic                 cpu_re,
  input  logic [31:0]          cpu_wdata,
  input  logic [3:0]           cpu_be,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_stall,
  output logic                 bus_err,
  output logic [NSLV-1:0]      slv_cs_n,
  output logic                 slv_we,
  output logic [31:0]          slv_addr,
  output logic [31:0]          slv_wdata,
  output logic [3:0]           slv_be,
  input  logic [NSLV*32-1:0]   slv_rdata,
  input  logic [NSLV-1:0]      slv_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [31:0]     r_rdata, w_rdata_nxt;
  logic            r_err, w_err_nxt;
  logic            w_req, w_rd, w_cs_en, w_any_hit, w_sel_ready;
  logic [NSLV-1:0] w_hit, w_sel;
  logic [31:0]     w_sel_rdata;

`ifdef RV32I_BUS_TIMEOUT_EN
  localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] r_cnt, w_cnt_nxt;
`endif

  // Gating with n_rst keeps stall and chip selects quiet while reset is held.
  assign w_req = n_rst & (cpu_re | cpu_we);
  assign w_rd  = cpu_re & ~cpu_we;

  genvar gi;
  generate
    for (gi = 0; gi < NSLV; gi++) begin : g_dec
      assign w_hit[gi] = ((cpu_addr & SLV_MASK[32*gi +: 32]) ==
                          (SLV_BASE[32*gi +: 32] & SLV_MASK[32*gi +: 32]));
    end
  endgenerate

  // Descending scan so the lowest matching slot is the last one written.
  always_comb begin
    w_sel = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_sel    = '0;
        w_sel[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      w_sel_rdata = w_sel_rdata | (slv_rdata[32*i +: 32] & {32{w_sel[i]}});
    end
  end

  assign w_any_hit   = |w_hit;
  assign w_sel_ready = |(w_sel & slv_ready);

  always_comb begin
    w_state_nxt = r_state;
    w_rdata_nxt = r_rdata;
    w_err_nxt   = 1'b0;
    w_cs_en     = 1'b0;
`ifdef RV32I_BUS_TIMEOUT_EN
    w_cnt_nxt   = r_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (!w_any_hit) begin
            w_state_nxt = S_RESP;
            w_err_nxt   = 1'b1;
            if (w_rd) w_rdata_nxt = ERR_RDATA;
          end else begin
            w_cs_en = 1'b1;
            if (w_sel_ready) begin
              w_state_nxt = S_RESP;
              if (w_rd) w_rdata_nxt = w_sel_rdata;
            end else begin
              w_state_nxt = S_WAIT;
`ifdef RV32I_BUS_TIMEOUT_EN
              w_cnt_nxt   = '0;
`endif
            end
          end
        end
      end
      S_WAIT: begin
        if (!w_req) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cs_en = w_any_hit;
          if (w_any_hit && w_sel_ready) begin
            w_state_nxt = S_RESP;
            if (w_rd) w_rdata_nxt = w_sel_rdata;
          end
`ifdef RV32I_BUS_TIMEOUT_EN
          else if (r_cnt == c_TO_LAST) begin
            w_state_nxt = S_RESP;
            w_err_nxt   = 1'b1;
            if (w_rd) w_rdata_nxt = ERR_RDATA;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
`endif
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rdata <= w_rdata_nxt;
      r_err   <= w_err_nxt;
    end
  end

`ifdef RV32I_BUS_TIMEOUT_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_cnt <= '0;
    else        r_cnt <= w_cnt_nxt;
  end
`endif

  assign slv_cs_n  = ~(w_sel & {NSLV{w_cs_en}});
  assign slv_we    = cpu_we & w_cs_en;
  assign slv_addr  = cpu_addr;
  assign slv_wdata = cpu_wdata;
  assign slv_be    = cpu_be;
  assign cpu_rdata = r_rdata;
  assign bus_err   = r_err;
  assign cpu_stall = w_req & (r_state != S_RESP);

endmodule
`default_nettype wire
